// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a 1-cycle registered-read instruction memory and
// presents {pc, instr} to decode under a valid/stall handshake with a one-entry skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] rsp_pc_reg, rsp_pc_next;
    logic        rsp_pending_reg, rsp_pending_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic        fault_reg, fault_next;

    logic out_free;
    logic pc_legal;
    logic redirect_legal;
    logic issue;

    function automatic logic is_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= LAST_PC);
    endfunction

    assign out_free       = !out_valid_reg || !stall;
    assign pc_legal       = is_legal(pc_reg);
    assign redirect_legal = is_legal(redirect_pc);
    assign issue          = (state_reg == RUN) && out_free && !redirect_valid && pc_legal;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        rsp_pending_next = rsp_pending_reg;
        skid_valid_next  = skid_valid_reg;
        skid_pc_next     = skid_pc_reg;
        skid_instr_next  = skid_instr_reg;
        out_valid_next   = out_valid_reg;
        out_pc_next      = out_pc_reg;
        out_instr_next   = out_instr_reg;
        fault_next       = fault_reg;

        if (redirect_valid) begin
            // Redirect discards everything in flight, regardless of stall.
            out_valid_next   = 1'b0;
            skid_valid_next  = 1'b0;
            rsp_pending_next = 1'b0;
            pc_next          = redirect_pc;
            state_next       = redirect_legal ? RUN : FAULT;
            fault_next       = !redirect_legal;
        end else begin
            rsp_pending_next = issue;
            if (issue) begin
                rsp_pc_next = pc_reg;
                pc_next     = pc_reg + 32'd4;
            end
            if (state_reg == RUN && !pc_legal) begin
                state_next = FAULT;
                fault_next = 1'b1;
            end

            // Stall blocks issue, so a response and a full skid never coincide.
            if (rsp_pending_reg) begin
                if (out_free && !skid_valid_reg) begin
                    out_valid_next = 1'b1;
                    out_pc_next    = rsp_pc_reg;
                    out_instr_next = imem_instr;
                end else begin
                    skid_valid_next = 1'b1;
                    skid_pc_next    = rsp_pc_reg;
                    skid_instr_next = imem_instr;
                end
            end

            if (out_free && skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_pc_next     = skid_pc_reg;
                out_instr_next  = skid_instr_reg;
                skid_valid_next = 1'b0;
            end else if (out_free && !rsp_pending_reg) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= 32'd0;
            rsp_pending_reg <= 1'b0;
            skid_valid_reg  <= 1'b0;
            skid_pc_reg     <= 32'd0;
            skid_instr_reg  <= 32'd0;
            out_valid_reg   <= 1'b0;
            out_pc_reg      <= 32'd0;
            out_instr_reg   <= 32'd0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            rsp_pending_reg <= rsp_pending_next;
            skid_valid_reg  <= skid_valid_next;
            skid_pc_reg     <= skid_pc_next;
            skid_instr_reg  <= skid_instr_next;
            out_valid_reg   <= out_valid_next;
            out_pc_reg      <= out_pc_next;
            out_instr_reg   <= out_instr_next;
            fault_reg       <= fault_next;
        end
    end

    assign imem_pc  = pc_reg;
    assign if_valid = out_valid_reg;
    assign if_pc    = out_pc_reg;
    assign if_instr = out_instr_reg;
    assign if_fault = fault_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage between the PC/branch logic and decode.
- Drives the byte address into the 1-cycle registered-read instruction memory.
- Realigns the returned word with its PC and presents {pc, instr} to decode under a valid/stall handshake.
- A one-entry skid buffer absorbs the in-flight memory read when decode stalls; supports redirect/flush and fault halting.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
MEM_SIZE, 512, instruction memory size in bytes; legal PCs satisfy pc <= MEM_SIZE-4

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
imem_pc  out  32  address presented to instruction memory (= pc_q)
imem_instr  in  32  memory read data; valid the cycle after imem_pc was sampled
stall  in  1  decode cannot accept this cycle
redirect_valid  in  1  branch/jump/trap redirect
redirect_pc  in  32  redirect target byte address
if_valid  out  1  if_pc/if_instr hold a valid instruction
if_pc  out  32  PC of presented instruction
if_instr  out  32  presented instruction
if_fault  out  1  fetch halted on misaligned or out-of-range PC

Behaviour:
- Reset: asynchronous on rst_n, active-high.
  - pc_q=RESET_PC, state=RUN.
  - rsp_pending=0, skid_valid=0.
  - if_valid=0, if_pc=0, if_instr=0, if_fault=0.
- Accept: the output is accepted when if_valid && !stall. out_free = !if_valid || !stall.
- Issue (RUN only): issue = out_free && !redirect_valid && pc_q legal (pc_q[1:0]==0, pc_q <= MEM_SIZE-4).
  - On issue: rsp_pc<=pc_q, rsp_pending<=1, pc_q<=pc_q+4.
  - Otherwise: rsp_pending<=0 and pc_q holds.
- Illegal pc_q in RUN:
  - No issue; state<=FAULT, if_fault<=1.
  - pc_q == MEM_SIZE (sequential run-off) faults; there is no wrap-around.
- Response routing, when rsp_pending:
  - If out_free and skid empty: {if_pc, if_instr}<={rsp_pc, imem_instr}, if_valid<=1.
  - Else: {skid_pc, skid_instr}<={rsp_pc, imem_instr}, skid_valid<=1.
- Skid drain:
  - When out_free and skid_valid: output<=skid, skid_valid<=0.
  - Otherwise, if out_free and no response arrives: if_valid<=0.
- Invariant: skid_valid and rsp_pending are never both 1 (assert in bench). Stall suppresses issue, so at most one read lands in the skid.
- Latency:
  - pc presented in cycle N, if_valid in cycle N+2.
  - Steady state: one instruction per cycle with stall=0.
  - Releasing stall with skid full costs no bubble.
- Redirect: highest priority, ignores stall.
  - Same edge: if_valid<=0, skid_valid<=0, rsp_pending<=0 (in-flight read discarded).
  - If redirect_pc legal: pc_q<=redirect_pc, state<=RUN, if_fault<=0. First redirected instruction is valid 2 cycles after the redirect edge.
  - If redirect_pc illegal: pc_q<=redirect_pc, state<=FAULT, if_fault<=1.
- FAULT:
  - No issue; an already-pending response/skid still drains normally.
  - Exits only on a legal redirect.
- Held outputs: if_pc/if_instr hold their value while if_valid && stall. When if_valid=0, their contents are don't-care.
- Reset mid-operation: all state returns to reset values immediately; the outstanding read is dropped.

Test Plan:
1. Reset release, memory preloaded with words 0x11..., 0x22..., 0x33... at 0/4/8, stall=0 -> if_valid rises 2 cycles after reset deassert; if_pc sequence 0,4,8, one per cycle, instrs matching.
2. Stall for 3 cycles while if_pc=4 -> if_pc=4 held all 3 cycles; pc 8 captured in skid, imem_pc frozen at 12; after release, if_pc=8 next cycle then 12, no bubble, no duplicates or drops.
3. Redirect to 0x40 during stall with skid full -> next cycle if_valid=0; if_pc=0x40 valid 2 cycles later; old pc 8/12 never presented.
4. Redirect to 0x42 -> if_fault=1, no further issues, if_valid drops; then redirect to 0x10 -> if_fault=0, if_pc=0x10 two cycles later.
5. Sequential fetch from 0x1F8 with MEM_SIZE=512 -> 0x1F8 and 0x1FC delivered; pc 0x200 raises if_fault, if_valid then 0, no wrap to 0.
6. Assert rst_n mid-stream with stall=1 and skid full -> if_valid/if_fault/skid cleared asynchronously; restart from RESET_PC after release, first if_valid 2 cycles later.
